pixel_write_master: RTL and testbench
=====================================

Name: pixel_write_master

Overview:
- Downstream neighbour of the pixel memory controller.
- Accepts one 24-bit colour word plus byte address per `wen` strobe into a small FIFO.
- Issues each entry as a single-word AHB-Lite write to the frame buffer.
- Throttles the controller through `buswait` when the FIFO is full, and reports completed-write and error-response counts.

Parameters:
- ASIZE, 32: address width.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous, active-low reset.
- address  input  ASIZE  byte address of pixel; word aligned by the producer.
- data  input  24  pixel colour {b,g,r}.
- wen  input  1  write request from controller.
- buswait  output  1  FIFO full; request not accepted.
- haddr  output  ASIZE  AHB address.
- htrans  output  2  AHB transfer type: 2'b00 IDLE, 2'b10 NONSEQ.
- hwrite  output  1  constant 1.
- hsize  output  3  constant 3'b010 (word).
- hburst  output  3  constant 3'b000 (SINGLE).
- hwdata  output  32  AHB write data.
- hready  input  1  AHB ready.
- hresp  input  1  AHB error response.
- idle  output  1  FIFO empty and no data phase outstanding.
- wr_count  output  16  completed OKAY writes; wraps at 16'hFFFF to 0.
- err_count  output  8  ERROR-terminated writes; saturates at 8'hFF.

Behaviour:
- Reset (async, n_rst low):
  - FIFO empty; read/write pointers 0; data-phase flag 0.
  - hwdata = 0; wr_count = 0; err_count = 0.
  - Outputs while in reset: htrans = IDLE, haddr = 0, buswait = 0, idle = 1.
  - Reset mid-transfer abandons all FIFO contents and any outstanding data phase; no count update.
- Push:
  - On a clk edge with wen = 1 and buswait = 0, store {address, data} at the write pointer.
  - buswait = (count == DEPTH), decoded from flops only; no combinational path from wen, hready or hresp.
  - wen while full is ignored; the entry is not stored.
  - A simultaneous pop does not free a slot for a push in the same cycle.
- Address phase:
  - When the FIFO is non-empty and not cancelling: htrans = NONSEQ and haddr = head address.
  - Otherwise htrans = IDLE and haddr = last driven address.
  - Accept (pop) happens on an edge with htrans = NONSEQ and hready = 1. Then:
    - read pointer advances;
    - hwdata <= {8'h00, head data};
    - data-phase flag <= 1.
- Data phase:
  - hwdata is held until an edge with hready = 1, which completes the phase.
  - A new address phase may overlap the data phase; the same hready edge completes the data phase and accepts the next address (back-to-back, one write per cycle at zero wait).
  - If no new address is accepted on completion, the data-phase flag <= 0.
- Completion:
  - hready = 1 and hresp = 0 with the data-phase flag set: wr_count + 1.
  - hready = 1 and hresp = 1: err_count + 1 (saturating); the entry is dropped, no retry.
- Error cancel:
  - In the first ERROR cycle (data-phase flag, hready = 0, hresp = 1), force htrans = IDLE.
  - The head entry is not popped and is reissued after the error completes.
- Latency:
  - Push at edge N; htrans = NONSEQ during cycle N+1 (empty FIFO, data path free).
  - Address accepted at edge N+1 if hready = 1; data-phase completion at edge N+2 at the earliest.
- Pointers: log2(DEPTH) bits, wrapping naturally. Occupancy count: log2(DEPTH)+1 bits, with push and pop in the same cycle leaving it unchanged.
- idle = (count == 0) and data-phase flag == 0.

Test Plan:
1. Reset, then single wen: address = 32'h0800_0000, data = 24'hFFAA55, hready = 1 → htrans = NONSEQ and haddr = 32'h0800_0000 the next cycle; following cycle hwdata = 32'h00FFAA55; wr_count = 1; idle returns to 1.
2. hready held 0, wen on every cycle with DEPTH = 4 → buswait = 1 after the 4th push; the 5th wen is ignored. Release hready → 4 writes at consecutive addresses in order; buswait deasserts after the first pop; wr_count = 4.
3. Back-to-back with hready = 1, 8 pushes of address 4k → haddr changes every cycle; each hwdata lags its haddr by exactly one cycle; wr_count = 8.
4. Wait states: hready = 0 for 3 cycles during a data phase → hwdata stable for all 3 cycles; next haddr held; no count change until hready = 1.
5. Two-cycle ERROR on the 2nd of 3 writes → htrans = IDLE in the first error cycle; err_count = 1; the 3rd write is issued afterwards; wr_count = 2.
6. Assert n_rst low while the FIFO holds 3 entries and a data phase is pending → immediately htrans = IDLE, buswait = 0, idle = 1, both counts = 0; no writes issue after release.

Source files
------------

// File: rtl/pixel_write_master_if.sv
// Producer-side write strobe plus AHB-Lite master bus and status for pixel_write_master.
interface pixel_write_master_if #(parameter int ASIZE = 32);
   logic [ASIZE-1:0] address;
   logic [23:0]      data;
   logic             wen;
   logic             buswait;
   logic [ASIZE-1:0] haddr;
   logic [1:0]       htrans;
   logic             hwrite;
   logic [2:0]       hsize;
   logic [2:0]       hburst;
   logic [31:0]      hwdata;
   logic             hready;
   logic             hresp;
   logic             idle;
   logic [15:0]      wr_count;
   logic [7:0]       err_count;

   modport master (
      input  address, data, wen, hready, hresp,
      output buswait, haddr, htrans, hwrite, hsize, hburst, hwdata, idle, wr_count, err_count
   );

   modport slave (
      output address, data, wen, hready, hresp,
      input  buswait, haddr, htrans, hwrite, hsize, hburst, hwdata, idle, wr_count, err_count
   );
endinterface

// File: rtl/pixel_write_master.sv
// Buffers pixel writes in a small FIFO and issues each as a single-word AHB-Lite write,
// counting OKAY completions and ERROR responses.
module pixel_write_master #(
   parameter int ASIZE = 32,
   parameter int DEPTH = 4
) (
   input logic                clk,
   input logic                n_rst,
   pixel_write_master_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef struct packed {
      logic [ASIZE-1:0] addr;
      logic [23:0]      data;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           head;
   logic [PW-1:0]    wptr, rptr;
   logic [PW:0]      count;
   logic             dphase;
   logic [ASIZE-1:0] haddr_q;
   logic [31:0]      hwdata_q;
   logic [15:0]      wr_cnt;
   logic [7:0]       err_cnt;
   logic             full, cancel, nonseq, push, pop, done;

   assign head   = mem[rptr];
   assign full   = (count == (PW+1)'(DEPTH));
   // First cycle of a two-cycle ERROR: the pending address phase must be withdrawn.
   assign cancel = dphase && !bus.hready && bus.hresp;
   assign nonseq = (count != '0) && !cancel;
   assign push   = bus.wen && !full;
   assign pop    = nonseq && bus.hready;
   assign done   = dphase && bus.hready;

   assign bus.buswait   = full;
   assign bus.htrans    = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign bus.haddr     = nonseq ? head.addr : haddr_q;
   assign bus.hwrite    = 1'b1;
   assign bus.hsize     = 3'b010;
   assign bus.hburst    = 3'b000;
   assign bus.hwdata    = hwdata_q;
   assign bus.idle      = (count == '0) && !dphase;
   assign bus.wr_count  = wr_cnt;
   assign bus.err_count = err_cnt;

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= '{addr: bus.address, data: bus.data};
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         dphase   <= 1'b0;
         haddr_q  <= '0;
         hwdata_q <= '0;
         wr_cnt   <= '0;
         err_cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (nonseq) haddr_q <= head.addr;
         if (pop) begin
            hwdata_q <= {8'h00, head.data};
            dphase   <= 1'b1;
         end else if (bus.hready) begin
            dphase   <= 1'b0;
         end
         if (done) begin
            if (bus.hresp) begin
               if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else begin
               wr_cnt <= wr_cnt + 16'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_pixel_write_master.sv
// Directed bench for pixel_write_master: single write, full FIFO, back-to-back,
// wait states, error cancel and reset mid-transfer.
module tb_pixel_write_master;
   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   pixel_write_master_if #(.ASIZE(32)) bus ();

   pixel_write_master #(.ASIZE(32), .DEPTH(4)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.address = '0;
      bus.data    = '0;
      bus.wen     = 1'b0;
      bus.hready  = 1'b1;
      bus.hresp   = 1'b0;
      #1;
      chk("rst_htrans", 32'(bus.htrans), 32'h0);
      chk("rst_haddr", bus.haddr, 32'h0);
      chk("rst_buswait", 32'(bus.buswait), 32'h0);
      chk("rst_idle", 32'(bus.idle), 32'h1);
      chk("rst_wr", 32'(bus.wr_count), 32'h0);
      chk("rst_err", 32'(bus.err_count), 32'h0);
      chk("const_hsize", 32'(bus.hsize), 32'h2);
      chk("const_hwrite", 32'(bus.hwrite), 32'h1);
      tick(); tick();
      n_rst = 1'b1;
      tick();

      // 1: single write
      bus.wen = 1'b1; bus.address = 32'h0800_0000; bus.data = 24'hFFAA55;
      tick();
      bus.wen = 1'b0; #1;
      chk("t1_htrans", 32'(bus.htrans), 32'h2);
      chk("t1_haddr", bus.haddr, 32'h0800_0000);
      chk("t1_idle0", 32'(bus.idle), 32'h0);
      tick();
      chk("t1_hwdata", bus.hwdata, 32'h00FFAA55);
      chk("t1_htrans_idle", 32'(bus.htrans), 32'h0);
      tick();
      chk("t1_wr", 32'(bus.wr_count), 32'd1);
      chk("t1_idle1", 32'(bus.idle), 32'h1);

      // 2: fill FIFO with hready low, 5th push dropped
      bus.hready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.wen = 1'b1; bus.address = 32'h100 + 32'(4*i); bus.data = 24'h10 + 24'(i);
         tick();
         if (i == 3) chk("t2_buswait_full", 32'(bus.buswait), 32'h1);
      end
      bus.wen = 1'b0; bus.hready = 1'b1; #1;
      chk("t2_haddr0", bus.haddr, 32'h100);
      for (int i = 1; i < 4; i++) begin
         tick();
         if (i == 1) chk("t2_buswait_free", 32'(bus.buswait), 32'h0);
         chk("t2_haddr", bus.haddr, 32'h100 + 32'(4*i));
         chk("t2_hwdata", bus.hwdata, 32'h10 + 32'(i-1));
      end
      tick();
      chk("t2_no5th", 32'(bus.htrans), 32'h0);
      chk("t2_hwdata3", bus.hwdata, 32'h13);
      tick();
      chk("t2_wr", 32'(bus.wr_count), 32'd5);

      // 3: back-to-back, zero wait
      for (int k = 0; k < 8; k++) begin
         bus.wen = 1'b1; bus.address = 32'(4*k); bus.data = 24'h300 + 24'(k);
         tick();
         chk("t3_haddr", bus.haddr, 32'(4*k));
         chk("t3_htrans", 32'(bus.htrans), 32'h2);
         if (k > 0) chk("t3_hwdata", bus.hwdata, 32'h300 + 32'(k-1));
      end
      bus.wen = 1'b0;
      tick();
      chk("t3_hwdata7", bus.hwdata, 32'h307);
      chk("t3_htrans_idle", 32'(bus.htrans), 32'h0);
      tick();
      chk("t3_wr", 32'(bus.wr_count), 32'd13);
      chk("t3_idle", 32'(bus.idle), 32'h1);

      // 4: three wait states in a data phase with the next address pending
      bus.wen = 1'b1; bus.address = 32'h500; bus.data = 24'hABCDEF;
      tick();
      bus.address = 32'h504; bus.data = 24'h123456;
      tick();
      bus.wen = 1'b0; bus.hready = 1'b0; #1;
      for (int w = 0; w < 3; w++) begin
         chk("t4_hwdata_hold", bus.hwdata, 32'h00ABCDEF);
         chk("t4_haddr_hold", bus.haddr, 32'h504);
         chk("t4_wr_hold", 32'(bus.wr_count), 32'd13);
         tick();
      end
      bus.hready = 1'b1; #1;
      chk("t4_wr_before", 32'(bus.wr_count), 32'd13);
      tick();
      chk("t4_wr_a", 32'(bus.wr_count), 32'd14);
      chk("t4_hwdata_b", bus.hwdata, 32'h00123456);
      tick();
      chk("t4_wr_b", 32'(bus.wr_count), 32'd15);

      // 5: two-cycle ERROR on the 2nd of 3 writes
      bus.hready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.wen = 1'b1; bus.address = 32'h600 + 32'(4*i); bus.data = 24'h600 + 24'(i);
         tick();
      end
      bus.wen = 1'b0; bus.hready = 1'b1;
      tick();
      tick();
      chk("t5_wr_first", 32'(bus.wr_count), 32'd16);
      chk("t5_hwdata_c1", bus.hwdata, 32'h601);
      bus.hready = 1'b0; bus.hresp = 1'b1; #1;
      chk("t5_cancel", 32'(bus.htrans), 32'h0);
      chk("t5_haddr_held", bus.haddr, 32'h604);
      tick();
      bus.hready = 1'b1; #1;
      chk("t5_reissue", 32'(bus.htrans), 32'h2);
      chk("t5_reissue_addr", bus.haddr, 32'h608);
      tick();
      bus.hresp = 1'b0; #1;
      chk("t5_err", 32'(bus.err_count), 32'd1);
      chk("t5_wr_mid", 32'(bus.wr_count), 32'd16);
      chk("t5_hwdata_c2", bus.hwdata, 32'h602);
      tick();
      chk("t5_wr", 32'(bus.wr_count), 32'd17);

      // 6: reset with 3 entries queued and a data phase pending
      bus.wen = 1'b1; bus.address = 32'h700; bus.data = 24'h700;
      tick();
      bus.address = 32'h704; bus.data = 24'h701;
      tick();
      bus.hready = 1'b0;
      bus.address = 32'h708; bus.data = 24'h702;
      tick();
      bus.address = 32'h70C; bus.data = 24'h703;
      tick();
      bus.wen = 1'b0; #1;
      chk("t6_pre_idle", 32'(bus.idle), 32'h0);
      n_rst = 1'b0; #1;
      chk("t6_htrans", 32'(bus.htrans), 32'h0);
      chk("t6_buswait", 32'(bus.buswait), 32'h0);
      chk("t6_idle", 32'(bus.idle), 32'h1);
      chk("t6_wr", 32'(bus.wr_count), 32'h0);
      chk("t6_err", 32'(bus.err_count), 32'h0);
      chk("t6_hwdata", bus.hwdata, 32'h0);
      tick();
      n_rst = 1'b1; bus.hready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_no_issue", 32'(bus.htrans), 32'h0);
      end
      chk("t6_wr_after", 32'(bus.wr_count), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
